// File: rtl/axis_to_uart_tx.sv
// AXI-Stream byte sink driving a UART transmit line.
// One frame per accepted word; back-to-back frames without idle gap.
module axis_to_uart_tx #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  output logic       tready,
  output logic       TX
);

  localparam int N =
    (CLK_FREQ * 1000000) / BIT_RATE;
  localparam int CNT_W =
    (N < 2) ? 1 : $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(N - 1);
  localparam logic [2:0] LAST_BIT =
    3'(BIT_PER_WORD - 1);
  localparam logic [7:0] MASK =
    8'((1 << BIT_PER_WORD) - 1);

  if (N < 2) begin : g_bad_rate
    $error("bit period below 2 cycles");
  end
  if (BIT_PER_WORD < 5 ||
      BIT_PER_WORD > 8) begin : g_bad_bpw
    $error("BIT_PER_WORD out of 5..8");
  end
  if (PARITY_BIT < 0 ||
      PARITY_BIT > 2) begin : g_bad_par
    $error("PARITY_BIT out of 0..2");
  end
  if (STOP_BITS_NUM < 1 ||
      STOP_BITS_NUM > 2) begin : g_bad_stop
    $error("STOP_BITS_NUM not 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_r;

  logic       last;
  logic       fin_stop;
  logic       hs;
  logic [7:0] wdata;
  logic       par_nxt;

  assign last  = (cnt == LAST_CNT);
  assign wdata = tdata & MASK;

  // Final stop symbol depends on the stop-bit count.
  always_comb begin
    fin_stop = 1'b0;
    if (STOP_BITS_NUM == 2)
      fin_stop = (state == S_STOP2);
    else
      fin_stop = (state == S_STOP1);
  end

  // Parity of the word being accepted, latched with it.
  always_comb begin
    par_nxt = 1'b0;
    if (PARITY_BIT == 1)
      par_nxt = ~^wdata;
    else if (PARITY_BIT == 2)
      par_nxt = ^wdata;
  end

  assign tready = (state == S_IDLE) ||
                  (fin_stop && last);
  assign hs     = tvalid && tready;

  // Frame sequencer; TX is registered and
  // the async reset forces the line idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_r   <= 1'b0;
      TX      <= 1'b1;
    end else if (hs) begin
      state   <= S_START;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= wdata;
      par_r   <= par_nxt;
      TX      <= 1'b0;
    end else if (state == S_IDLE) begin
      cnt     <= '0;
      bit_cnt <= '0;
      TX      <= 1'b1;
    end else if (!last) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
      unique case (state)
        S_START: begin
          state <= S_DATA;
          TX    <= shreg[0];
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (PARITY_BIT != 0) begin
              state <= S_PARITY;
              TX    <= par_r;
            end else begin
              state <= S_STOP1;
              TX    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= shreg >> 1;
            TX      <= shreg[1];
          end
        end
        S_PARITY: begin
          state <= S_STOP1;
          TX    <= 1'b1;
        end
        S_STOP1: begin
          if (STOP_BITS_NUM == 2)
            state <= S_STOP2;
          else
            state <= S_IDLE;
          TX <= 1'b1;
        end
        S_STOP2: begin
          state <= S_IDLE;
          TX    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Bench for axis_to_uart_tx at N=10.
// Four line formats checked against a frame model.
module tb_axis_to_uart_tx;

  localparam int N = 10;
  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int STP [4] = '{1, 1, 1, 2};

  typedef bit bq_t[$];

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [3:0] tv;
  logic [7:0] td [4];
  logic [3:0] txv;
  logic [3:0] rdy;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axis_to_uart_tx #(
    .CLK_FREQ(100), .BIT_RATE(10_000_000),
    .BIT_PER_WORD(8), .PARITY_BIT(0),
    .STOP_BITS_NUM(1)
  ) u_8n1 (
    .aclk(aclk), .aresetn(aresetn),
    .tdata(td[0]), .tvalid(tv[0]),
    .tready(rdy[0]), .TX(txv[0])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(100), .BIT_RATE(10_000_000),
    .BIT_PER_WORD(8), .PARITY_BIT(1),
    .STOP_BITS_NUM(1)
  ) u_8o1 (
    .aclk(aclk), .aresetn(aresetn),
    .tdata(td[1]), .tvalid(tv[1]),
    .tready(rdy[1]), .TX(txv[1])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(100), .BIT_RATE(10_000_000),
    .BIT_PER_WORD(8), .PARITY_BIT(2),
    .STOP_BITS_NUM(1)
  ) u_8e1 (
    .aclk(aclk), .aresetn(aresetn),
    .tdata(td[2]), .tvalid(tv[2]),
    .tready(rdy[2]), .TX(txv[2])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(100), .BIT_RATE(10_000_000),
    .BIT_PER_WORD(8), .PARITY_BIT(0),
    .STOP_BITS_NUM(2)
  ) u_8n2 (
    .aclk(aclk), .aresetn(aresetn),
    .tdata(td[3]), .tvalid(tv[3]),
    .tready(rdy[3]), .TX(txv[3])
  );

  task automatic chk(string tag,
                     logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b",
             tag, obs, exp);
    end
  endtask

  // Line symbols of one frame, in send order.
  function automatic bq_t frame_bits(
    int k, logic [7:0] d);
    bq_t q;
    int  ones;
    ones = $countones(d);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      q.push_back(d[i]);
    if (PAR[k] == 1)
      q.push_back((ones % 2) == 0);
    else if (PAR[k] == 2)
      q.push_back((ones % 2) == 1);
    for (int s = 0; s < STP[k]; s++)
      q.push_back(1'b1);
    return q;
  endfunction

  // Offer d on lane k until accepted.
  task automatic hs(int k, logic [7:0] d);
    logic r;
    bit   ok;
    ok = 1'b0;
    tv[k] = 1'b1;
    td[k] = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      r = rdy[k];
      @(posedge aclk);
      ok = r;
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL hs_timeout k=%0d obs=0 exp=1",
             k);
    end
    @(negedge aclk);
  endtask

  // Check every cycle of an accepted frame.
  task automatic frame(int k, logic [7:0] d,
                       bit b2b,
                       logic [7:0] d2);
    bq_t q;
    int  len;
    q   = frame_bits(k, d);
    len = q.size() * N;
    for (int c = 0; c < len; c++) begin
      chk($sformatf("k%0d d%02h tx c%0d",
                    k, d, c),
          txv[k], q[c / N]);
      chk($sformatf("k%0d d%02h rdy c%0d",
                    k, d, c),
          rdy[k], c == len - 1);
      if (b2b) begin
        tv[k] = 1'b1;
        td[k] = d2;
      end else begin
        tv[k] = 1'b0;
        td[k] = 8'($urandom);
      end
      @(negedge aclk);
    end
  endtask

  task automatic idle_chk(int k, string tag);
    chk({tag, "_tx"}, txv[k], 1'b1);
    chk({tag, "_rdy"}, rdy[k], 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    int         k;
    bit         b2b;

    tv = '0;
    for (int i = 0; i < 4; i++)
      td[i] = 8'h00;

    repeat (3) @(negedge aclk);
    for (int i = 0; i < 4; i++)
      idle_chk(i, $sformatf("rst%0d", i));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    hs(0, 8'hA5);
    frame(0, 8'hA5, 1'b0, 8'h00);
    idle_chk(0, "a5_after");

    hs(1, 8'h03);
    frame(1, 8'h03, 1'b0, 8'h00);
    hs(2, 8'h07);
    frame(2, 8'h07, 1'b0, 8'h00);
    hs(2, 8'h03);
    frame(2, 8'h03, 1'b0, 8'h00);
    idle_chk(2, "par_after");

    hs(0, 8'h55);
    frame(0, 8'h55, 1'b1, 8'hAA);
    frame(0, 8'hAA, 1'b0, 8'h00);
    idle_chk(0, "b2b_after");

    hs(3, 8'hFF);
    frame(3, 8'hFF, 1'b0, 8'h00);
    idle_chk(3, "stop2_after");

    for (int it = 0; it < 24; it++) begin
      k   = $urandom_range(0, 3);
      d   = 8'($urandom);
      d2  = 8'($urandom);
      b2b = 1'($urandom);
      hs(k, d);
      frame(k, d, b2b, d2);
      if (b2b)
        frame(k, d2, 1'b0, 8'h00);
      idle_chk(k, $sformatf("rnd%0d", it));
    end

    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("quiet k%0d c%0d tx",
                      i, c), txv[i], 1'b1);
        chk($sformatf("quiet k%0d c%0d rdy",
                      i, c), rdy[i], 1'b1);
        td[i] = 8'($urandom);
      end
      @(negedge aclk);
    end

    hs(0, 8'hC3);
    tv[0] = 1'b0;
    repeat (45) @(negedge aclk);
    chk("mid_bit3_low", txv[0], 1'b0);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tx", txv[0], 1'b1);
    chk("arst_rdy", rdy[0], 1'b1);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      idle_chk(0, $sformatf("post_rst%0d", c));
      @(negedge aclk);
    end
    hs(0, 8'h3C);
    frame(0, 8'h3C, 1'b0, 8'h00);
    idle_chk(0, "3c_after");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/axis_to_uart_tx.md
AXIS_TO_UART_TX -- requirements
Module: axis_to_uart_tx

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
  CLK_FREQ       100      clock frequency, MHz
  BIT_RATE       115200   line rate, bit/s
  BIT_PER_WORD   8        data bits per frame, 5..8
  PARITY_BIT     0        0 none, 1 odd, 2 even
  STOP_BITS_NUM  1        stop bits, 1 or 2
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
  aclk     in   1  clock
  aresetn  in   1  reset, asynchronous, active-low
  tdata    in   8  AXI-Stream data word to transmit
  tvalid   in   1  AXI-Stream valid
  tready   out  1  AXI-Stream ready
  TX       out  1  UART serial line, idle high
REQ-003 The module SHALL use one clock domain, aclk; aresetn SHALL be asynchronous assert, active-low.

Function
REQ-004 The module SHALL define the bit period as N = CLK_FREQ*10^6/BIT_RATE clock cycles, using integer division (100 MHz / 115200 gives N = 868).
REQ-005 Every line symbol (start, data, parity, stop) SHALL be driven for exactly N cycles, timed by a cycle counter that counts 0..N-1 and wraps to 0.
REQ-006 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-007 A handshake SHALL occur on a rising edge of aclk where tvalid=1 and tready=1. On that edge, tdata[BIT_PER_WORD-1:0] SHALL be captured into the shift register and the FSM SHALL enter START.
REQ-008 tdata bits above BIT_PER_WORD-1 SHALL be ignored.
REQ-009 TX SHALL be a registered output. It SHALL be 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in IDLE, STOP1 and STOP2.
REQ-010 TX SHALL first go low in the cycle immediately after the handshake edge.
REQ-011 Data bits SHALL be sent LSB first. A bit counter SHALL advance at the end of each data-bit period, and DATA SHALL exit after BIT_PER_WORD bits.
REQ-012 The FSM SHALL go DATA -> PARITY if PARITY_BIT != 0, otherwise DATA -> STOP1.
REQ-013 The parity bit SHALL be computed from the captured word. For odd parity, data bits plus parity bit SHALL contain an odd number of 1s. For even parity, they SHALL contain an even number of 1s.
REQ-014 The FSM SHALL go STOP1 -> STOP2 if STOP_BITS_NUM == 2, otherwise STOP1 -> IDLE or START per REQ-016.
REQ-015 tready SHALL be 1 in IDLE and in the last cycle (count N-1) of the final stop bit, and 0 in all other cycles.
REQ-016 A handshake in the last cycle of the final stop bit SHALL go directly to START, giving back-to-back frames with no idle gap. Without a handshake, the FSM SHALL go to IDLE.
REQ-017 Frame length SHALL be (1 + BIT_PER_WORD + (PARITY_BIT != 0) + STOP_BITS_NUM) * N cycles.
REQ-018 tdata changes while tready=0 SHALL NOT affect the frame in progress.
REQ-019 In IDLE with tvalid=0, TX SHALL stay 1 and both counters SHALL hold at 0.
REQ-020 The cycle counter width SHALL hold N-1 for all legal parameter values. N < 2 SHALL be rejected at elaboration.

Reset
REQ-021 While aresetn=0, the module SHALL hold State=IDLE, TX=1, tready=1, cycle counter=0, bit counter=0, shift register=0, and parity register=0.
REQ-022 Assertion of aresetn mid-frame SHALL force TX=1 immediately, without waiting for a clock edge, and SHALL abandon the frame. No partial frame SHALL resume after release.
REQ-023 The first handshake after aresetn is released SHALL produce a complete, correct frame.

Verification (CLK_FREQ=100, BIT_RATE=10_000_000, so N=10)
REQ-024 8N1, send 0xA5 -> TX = start 0 x10, then bits 1,0,1,0,0,1,0,1 (x10 each), then stop 1 x10. tready SHALL be low for 99 cycles, then high in the last stop cycle.
REQ-025 PARITY_BIT=1, send 0x03 -> parity bit 1; PARITY_BIT=2, send 0x07 -> parity bit 1; PARITY_BIT=2, send 0x03 -> parity bit 0. Each frame SHALL be 110 cycles.
REQ-026 tvalid held high, send 0x55 then 0xAA -> the second start bit SHALL begin the cycle after the first frame's final stop cycle, with no idle gap. Both bytes SHALL decode correctly.
REQ-027 STOP_BITS_NUM=2, send 0xFF -> TX high for 20 cycles after the last data bit. tready=1 only in the 20th of those cycles. Frame length SHALL be 110 cycles.
REQ-028 Assert aresetn=0 during data bit 3 -> TX=1 and tready=1 in the same cycle. After release, sending 0x3C SHALL produce a clean 100-cycle frame.
REQ-029 tvalid=0 for 500 cycles while tdata toggles -> TX stays 1, tready stays 1, and no start bit appears.
